// File: rtl/page_sequencer.sv
// page_sequencer: menu/page controller for the VGA UI.
// Turns PS2 key levels into press events (edge detect plus auto-repeat on the
// config page), sequences the page selection, holds the player-count setting
// and generates a frame-counted blanking window after every page change.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   keys[4:0]    key levels: 0 up, 1 left, 2 right, 3 down, 4 space
//   frame_start  one-cycle strobe per video frame
//   game_over    one-cycle strobe from game logic (honoured only on the game page)
//   page[1:0]    0 main, 1 help, 2 config, 3 game
//   disp_num     player count, NUM_MIN..NUM_MAX
//   game_start   one-cycle pulse, coincident with page first reading 3
//   blank        high during the post-transition blanking window
module page_sequencer #(
  parameter int unsigned NUM_MIN      = 2,
  parameter int unsigned NUM_MAX      = 5,
  parameter int unsigned NUM_INIT     = 2,
  parameter int unsigned BLANK_FRAMES = 4,
  parameter int unsigned REPEAT_START = 30,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] keys,
  input  logic       frame_start,
  input  logic       game_over,
  output logic [1:0] page,
  output logic [2:0] disp_num,
  output logic       game_start,
  output logic       blank
);

  typedef enum logic [1:0] {
    PG_MAIN   = 2'd0,
    PG_HELP   = 2'd1,
    PG_CONFIG = 2'd2,
    PG_GAME   = 2'd3
  } page_t;

  localparam logic [2:0] LP_NUM_MIN    = 3'(NUM_MIN);
  localparam logic [2:0] LP_NUM_MAX    = 3'(NUM_MAX);
  localparam logic [2:0] LP_NUM_INIT   = 3'(NUM_INIT);
  localparam logic [7:0] LP_BLANK      = 8'(BLANK_FRAMES);
  localparam logic [5:0] LP_REP_LAST   = 6'(REPEAT_START - 1);
  localparam logic [5:0] LP_REP_RELOAD = 6'(REPEAT_START - REPEAT_RATE);

  page_t      r_page;
  page_t      w_page_nxt;
  logic [4:0] r_k1;
  logic [4:0] r_k2;
  logic [4:0] w_edge;
  logic [4:0] w_ev;
  logic [4:0] w_sel;
  logic [5:0] r_hold;
  logic       w_hold_run;
  logic       w_rep_fire;
  logic [7:0] r_blank_cnt;
  logic       r_blank;
  logic [2:0] r_num;
  logic [2:0] w_num_nxt;
  logic       r_game_start;
  logic       w_game_start_nxt;
  logic       w_page_chg;

  // Key synchronizer / edge detector. Reset to 0 so a key held through reset
  // produces a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k1 <= '0;
      r_k2 <= '0;
    end else begin
      r_k1 <= keys;
      r_k2 <= r_k1;
    end
  end

  assign w_edge = r_k1 & ~r_k2;

  // Hold counter runs only with exactly one of left/right held on the config
  // page and no fresh left/right edge this cycle; an edge clears it and
  // suppresses a coincident frame increment.
  assign w_hold_run = (r_page == PG_CONFIG) && (r_k1[1] ^ r_k1[2]) &&
                      !(w_edge[1] || w_edge[2]);
  assign w_rep_fire = w_hold_run && frame_start && (r_hold == LP_REP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (!w_hold_run) begin
      r_hold <= '0;
    end else if (frame_start) begin
      if (r_hold == LP_REP_LAST) r_hold <= LP_REP_RELOAD;
      else                       r_hold <= r_hold + 6'd1;
    end
  end

  // Repeat events merge into the edge event of the same key; everything is
  // dropped while blanked.
  assign w_ev = r_blank ? '0
              : (w_edge | {2'b00, w_rep_fire & r_k1[2], w_rep_fire & r_k1[1], 1'b0});

  // Fixed priority: up > left > right > down > space.
  always_comb begin
    w_sel = '0;
    if      (w_ev[0]) w_sel[0] = 1'b1;
    else if (w_ev[1]) w_sel[1] = 1'b1;
    else if (w_ev[2]) w_sel[2] = 1'b1;
    else if (w_ev[3]) w_sel[3] = 1'b1;
    else if (w_ev[4]) w_sel[4] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_page       <= PG_MAIN;
      r_num        <= LP_NUM_INIT;
      r_game_start <= 1'b0;
    end else begin
      r_page       <= w_page_nxt;
      r_num        <= w_num_nxt;
      r_game_start <= w_game_start_nxt;
    end
  end

  always_comb begin
    w_page_nxt       = r_page;
    w_num_nxt        = r_num;
    w_game_start_nxt = 1'b0;
    unique case (r_page)
      PG_MAIN: begin
        if      (w_sel[0]) w_page_nxt = PG_CONFIG;
        else if (w_sel[3]) w_page_nxt = PG_HELP;
      end
      PG_HELP: begin
        if (w_sel[3]) w_page_nxt = PG_MAIN;
      end
      PG_CONFIG: begin
        if (w_sel[1]) begin
          if (r_num > LP_NUM_MIN) w_num_nxt = r_num - 3'd1;
        end else if (w_sel[2]) begin
          if (r_num < LP_NUM_MAX) w_num_nxt = r_num + 3'd1;
        end else if (w_sel[3]) begin
          w_page_nxt = PG_MAIN;
        end else if (w_sel[4]) begin
          w_page_nxt       = PG_GAME;
          w_game_start_nxt = 1'b1;
        end
      end
      PG_GAME: begin
        if (game_over) w_page_nxt = PG_MAIN;
      end
      default: w_page_nxt = PG_MAIN;
    endcase
  end

  assign w_page_chg = (w_page_nxt != r_page);

  // Blanking: a page change reloads (wins over a coincident decrement);
  // blank drops on the edge after the count has reached zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (w_page_chg) begin
      r_blank_cnt <= LP_BLANK;
      r_blank     <= 1'b1;
    end else if (r_blank) begin
      if (r_blank_cnt == 8'd0)  r_blank     <= 1'b0;
      else if (frame_start)     r_blank_cnt <= r_blank_cnt - 8'd1;
    end
  end

  assign page       = r_page;
  assign disp_num   = r_num;
  assign game_start = r_game_start;
  assign blank      = r_blank;

endmodule

// File: tb/tb_page_sequencer.sv
// Self-checking bench for page_sequencer. Expected output vectors
// {page, disp_num, blank, game_start} are queued as stimulus is driven and
// popped when the DUT outputs are sampled (1 time unit after the clock edge).
module tb_page_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] keys;
  logic       frame_start;
  logic       game_over;
  logic [1:0] page;
  logic [2:0] disp_num;
  logic       game_start;
  logic       blank;

  page_sequencer #(
    .NUM_MIN      (2),
    .NUM_MAX      (5),
    .NUM_INIT     (2),
    .BLANK_FRAMES (4),
    .REPEAT_START (30),
    .REPEAT_RATE  (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys        (keys),
    .frame_start (frame_start),
    .game_over   (game_over),
    .page        (page),
    .disp_num    (disp_num),
    .game_start  (game_start),
    .blank       (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] K_UP = 5'b00001, K_LEFT = 5'b00010, K_RIGHT = 5'b00100,
                         K_DOWN = 5'b01000, K_SPACE = 5'b10000;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic logic [6:0] mk(input logic [1:0] pg, input logic [2:0] num,
                                    input logic bl, input logic gs);
    return {pg, num, bl, gs};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got page=%0d num=%0d blank=%0b gs=%0b, expected page=%0d num=%0d blank=%0b gs=%0b",
               tag, got[6:5], got[4:2], got[1], got[0], exp[6:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [6:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic observe();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: sample with empty expectation queue");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {page, disp_num, blank, game_start}, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key pulse: sampled into k1 at the first edge, result visible after the second.
  task automatic press(input logic [4:0] k);
    keys = k;
    tick();
    keys = '0;
    tick();
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  // Four frames bring the count to zero; blank drops one edge later.
  task automatic unblank();
    frames(4);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    keys = '0;
    frame_start = 1'b0;
    game_over = 1'b0;
    tick();
    tick();
    expect_out("reset_state", mk(2'd0, 3'd2, 1'b0, 1'b0));
    observe();
    rst = 1'b0;
    tick();
    expect_out("idle_after_reset", mk(2'd0, 3'd2, 1'b0, 1'b0));
    observe();

    // Navigation
    expect_out("main_up_to_config", mk(2'd2, 3'd2, 1'b1, 1'b0));
    press(K_UP);
    observe();
    frames(3);
    tick();
    expect_out("blank_still_after_3_frames", mk(2'd2, 3'd2, 1'b1, 1'b0));
    observe();
    frames(1);
    tick();
    expect_out("blank_clear_after_4_frames", mk(2'd2, 3'd2, 1'b0, 1'b0));
    observe();
    expect_out("config_down_to_main", mk(2'd0, 3'd2, 1'b1, 1'b0));
    press(K_DOWN);
    observe();
    unblank();
    expect_out("main_down_to_help", mk(2'd1, 3'd2, 1'b1, 1'b0));
    press(K_DOWN);
    observe();
    unblank();
    expect_out("help_up_ignored", mk(2'd1, 3'd2, 1'b0, 1'b0));
    press(K_UP);
    observe();
    expect_out("help_down_to_main", mk(2'd0, 3'd2, 1'b1, 1'b0));
    press(K_DOWN);
    observe();
    unblank();
    press(K_UP);
    unblank();
    expect_out("config_reached", mk(2'd2, 3'd2, 1'b0, 1'b0));
    observe();

    // Saturation
    begin
      logic [2:0] up_seq [5] = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
      logic [2:0] dn_seq [5] = '{3'd4, 3'd3, 3'd2, 3'd2, 3'd2};
      for (int i = 0; i < 5; i++) begin
        expect_out($sformatf("right_sat_%0d", i), mk(2'd2, up_seq[i], 1'b0, 1'b0));
        press(K_RIGHT);
        observe();
      end
      for (int i = 0; i < 5; i++) begin
        expect_out($sformatf("left_sat_%0d", i), mk(2'd2, dn_seq[i], 1'b0, 1'b0));
        press(K_LEFT);
        observe();
      end
    end

    // Auto-repeat: the press edge steps 2->3, then first repeat on frame 30,
    // later ones every 6 frames.
    keys = K_RIGHT;
    tick();
    tick();
    expect_out("hold_right_edge", mk(2'd2, 3'd3, 1'b0, 1'b0));
    observe();
    frames(29);
    expect_out("hold_right_29_frames", mk(2'd2, 3'd3, 1'b0, 1'b0));
    observe();
    frames(1);
    expect_out("hold_right_first_repeat", mk(2'd2, 3'd4, 1'b0, 1'b0));
    observe();
    frames(5);
    expect_out("hold_right_5_more", mk(2'd2, 3'd4, 1'b0, 1'b0));
    observe();
    frames(1);
    expect_out("hold_right_second_repeat", mk(2'd2, 3'd5, 1'b0, 1'b0));
    observe();
    frames(12);
    expect_out("hold_right_saturated", mk(2'd2, 3'd5, 1'b0, 1'b0));
    observe();
    keys = '0;
    tick();
    keys = K_LEFT;
    tick();
    tick();
    expect_out("hold_left_edge", mk(2'd2, 3'd4, 1'b0, 1'b0));
    observe();
    frames(29);
    expect_out("hold_left_29_frames", mk(2'd2, 3'd4, 1'b0, 1'b0));
    observe();
    frames(1);
    expect_out("hold_left_repeat", mk(2'd2, 3'd3, 1'b0, 1'b0));
    observe();
    keys = '0;
    tick();

    // Priority and blanking
    press(K_DOWN);
    unblank();
    expect_out("up_down_same_cycle", mk(2'd2, 3'd3, 1'b1, 1'b0));
    press(K_UP | K_DOWN);
    observe();
    expect_out("right_while_blank", mk(2'd2, 3'd3, 1'b1, 1'b0));
    press(K_RIGHT);
    observe();
    unblank();
    expect_out("left_right_same_cycle", mk(2'd2, 3'd2, 1'b0, 1'b0));
    press(K_LEFT | K_RIGHT);
    observe();
    expect_out("right_after_blank", mk(2'd2, 3'd3, 1'b0, 1'b0));
    press(K_RIGHT);
    observe();

    // Game round trip
    expect_out("space_to_game", mk(2'd3, 3'd3, 1'b1, 1'b1));
    press(K_SPACE);
    observe();
    tick();
    expect_out("game_start_one_cycle", mk(2'd3, 3'd3, 1'b1, 1'b0));
    observe();
    expect_out("keys_ignored_in_game", mk(2'd3, 3'd3, 1'b1, 1'b0));
    press(K_DOWN);
    observe();
    frames(2);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    expect_out("game_over_during_blank", mk(2'd0, 3'd3, 1'b1, 1'b0));
    observe();
    frames(3);
    tick();
    expect_out("blank_reloaded_3_frames", mk(2'd0, 3'd3, 1'b1, 1'b0));
    observe();
    frames(1);
    tick();
    expect_out("blank_reloaded_4_frames", mk(2'd0, 3'd3, 1'b0, 1'b0));
    observe();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    tick();
    expect_out("game_over_in_main_ignored", mk(2'd0, 3'd3, 1'b0, 1'b0));
    observe();

    // Mid-operation reset
    press(K_UP);
    unblank();
    press(K_RIGHT);
    press(K_DOWN);
    unblank();
    press(K_UP);
    expect_out("pre_reset_state", mk(2'd2, 3'd4, 1'b1, 1'b0));
    observe();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("mid_op_reset", mk(2'd0, 3'd2, 1'b0, 1'b0));
    observe();
    tick();
    expect_out("post_reset_stable", mk(2'd0, 3'd2, 1'b0, 1'b0));
    observe();

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
